// File: rtl/mission_sequencer_pkg.sv
// Shared encodings for the mission sequencer: FSM state type, seven-segment
// state nibbles and the default colour-code width.
package mission_sequencer_pkg;

  localparam int COLOR_W_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TRACK = 3'd2,
    S_BUZZ  = 3'd3,
    S_UTURN = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [3:0] SSD_IDLE  = 4'h0;
  localparam logic [3:0] SSD_LOAD  = 4'h1;
  localparam logic [3:0] SSD_TRACK = 4'h2;
  localparam logic [3:0] SSD_BUZZ  = 4'h3;
  localparam logic [3:0] SSD_UTURN = 4'h4;
  localparam logic [3:0] SSD_DONE  = 4'h5;
  localparam logic [3:0] SSD_FAULT = 4'hF;

  function automatic logic [3:0] ssd_state_code(input state_t s);
    case (s)
      S_IDLE:  ssd_state_code = SSD_IDLE;
      S_LOAD:  ssd_state_code = SSD_LOAD;
      S_TRACK: ssd_state_code = SSD_TRACK;
      S_BUZZ:  ssd_state_code = SSD_BUZZ;
      S_UTURN: ssd_state_code = SSD_UTURN;
      S_DONE:  ssd_state_code = SSD_DONE;
      default: ssd_state_code = SSD_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/mission_sequencer_if.sv
// Sensor/actuator bundle between the mission sequencer and its neighbours.
// master = sensor front-ends and actuator blocks, slave = the sequencer.
interface mission_sequencer_if
  import mission_sequencer_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEF
);
  logic               tick_ms;
  logic               hall;
  logic [COLOR_W-1:0] object_color;
  logic               object_valid;
  logic [COLOR_W-1:0] station_color;
  logic               station_valid;
  logic               end_of_track;
  logic               uturn_finished;
  logic               buzz_finished;
  logic               en_tracking;
  logic               en_uturn;
  logic               en_buzz;
  logic [15:0]        ssd_code;
  logic               mission_done;
  logic               fault;

  modport master (
    output tick_ms, hall, object_color, object_valid, station_color, station_valid,
           end_of_track, uturn_finished, buzz_finished,
    input  en_tracking, en_uturn, en_buzz, ssd_code, mission_done, fault
  );

  modport slave (
    input  tick_ms, hall, object_color, object_valid, station_color, station_valid,
           end_of_track, uturn_finished, buzz_finished,
    output en_tracking, en_uturn, en_buzz, ssd_code, mission_done, fault
  );

endinterface

// File: rtl/mission_sequencer_hall_debounce.sv
// Hall sensor synchroniser and debouncer: the output follows the synchronised
// input only after it has differed for DEBOUNCE_MS consecutive ms ticks.
module hall_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // cnt is a down-counter of remaining mismatch ticks; any agreement reloads it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      dout   <= 1'b0;
      cnt    <= CW'(DEBOUNCE_MS);
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      if (sync_2 == dout) begin
        cnt <= CW'(DEBOUNCE_MS);
      end else if (tick_ms) begin
        if (cnt == CW'(1)) begin
          dout <= sync_2;
          cnt  <= CW'(DEBOUNCE_MS);
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mission_sequencer.sv
// Delivery mission controller: load object, track line, buzz at matching
// station, U-turn at end of track; DONE after N_DELIVERIES, FAULT on stalls.
//
//   state | meaning
//   IDLE  | waiting for a debounced hall rising edge (object placed)
//   LOAD  | waiting for the object colour classification
//   TRACK | line tracking; watching stations, end of track and timeout
//   BUZZ  | buzzer running at the matching station
//   UTURN | U-turn manoeuvre at end of track
//   DONE  | all deliveries made, terminal until reset
//   FAULT | timeout or too many empty U-turns, terminal until reset
module mission_sequencer
  import mission_sequencer_pkg::*;
#(
  parameter int COLOR_W          = COLOR_W_DEF,
  parameter int N_DELIVERIES     = 3,
  parameter int DEBOUNCE_MS      = 20,
  parameter int TIMEOUT_MS       = 30000,
  parameter int MAX_EMPTY_UTURNS = 2
) (
  input logic                clk,
  input logic                rst,
  mission_sequencer_if.slave bus
);
  localparam int         TW        = $clog2(TIMEOUT_MS + 1);
  localparam int         EW        = $clog2(MAX_EMPTY_UTURNS + 1);
  localparam logic [3:0] GOAL_TENS = 4'(N_DELIVERIES / 10);
  localparam logic [3:0] GOAL_ONES = 4'(N_DELIVERIES % 10);

  state_t             state;
  state_t             nxt;
  logic               hall_db;
  logic               hall_db_d;
  logic               hall_rise;
  logic               hall_fall;
  logic [TW-1:0]      timer;
  logic [EW-1:0]      empty_cnt;
  logic [COLOR_W-1:0] obj_q;
  logic [3:0]         dlv_tens;
  logic [3:0]         dlv_ones;
  logic               delivered;
  logic               station_match;
  logic               goal_reached;
  logic               last_empty;
  logic               en_tracking_q;
  logic               en_uturn_q;
  logic               en_buzz_q;
  logic               mission_done_q;
  logic               fault_q;

  hall_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_hall_debounce (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (bus.tick_ms),
    .din     (bus.hall),
    .dout    (hall_db)
  );

  assign hall_rise     = hall_db & ~hall_db_d;
  assign hall_fall     = ~hall_db & hall_db_d;
  assign station_match = bus.station_valid && (bus.station_color == obj_q) && !delivered;
  assign goal_reached  = (dlv_tens == GOAL_TENS) && (dlv_ones == GOAL_ONES);
  assign last_empty    = (empty_cnt == EW'(MAX_EMPTY_UTURNS - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (hall_rise) nxt = S_LOAD;
      S_LOAD: begin
        if (bus.object_valid)   nxt = S_TRACK;
        else if (hall_fall)     nxt = S_IDLE;
      end
      S_TRACK: begin
        if (station_match)         nxt = S_BUZZ;
        else if (bus.end_of_track) nxt = S_UTURN;
        else if (timer == '0)      nxt = S_FAULT;
      end
      S_BUZZ:  if (bus.buzz_finished) nxt = S_TRACK;
      S_UTURN: begin
        if (bus.uturn_finished) begin
          if (delivered)       nxt = goal_reached ? S_DONE : S_IDLE;
          else if (last_empty) nxt = S_FAULT;
          else                 nxt = S_TRACK;
        end
      end
      S_DONE:  nxt = S_DONE;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from nxt so they change together with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      hall_db_d      <= 1'b0;
      timer          <= TW'(TIMEOUT_MS);
      empty_cnt      <= '0;
      obj_q          <= '0;
      dlv_tens       <= 4'd0;
      dlv_ones       <= 4'd0;
      delivered      <= 1'b0;
      en_tracking_q  <= 1'b0;
      en_uturn_q     <= 1'b0;
      en_buzz_q      <= 1'b0;
      mission_done_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state          <= nxt;
      hall_db_d      <= hall_db;
      en_tracking_q  <= (nxt == S_TRACK);
      en_uturn_q     <= (nxt == S_UTURN);
      en_buzz_q      <= (nxt == S_BUZZ) || (nxt == S_FAULT);
      mission_done_q <= (nxt == S_DONE);
      fault_q        <= (nxt == S_FAULT);

      // Timeout down-counter restarts on every state entry
      if (nxt != state) begin
        timer <= TW'(TIMEOUT_MS);
      end else if (bus.tick_ms && timer != '0) begin
        timer <= timer - TW'(1);
      end

      if (state == S_LOAD && bus.object_valid) begin
        obj_q <= bus.object_color;
      end

      if (state == S_BUZZ && bus.buzz_finished) begin
        delivered <= 1'b1;
        if (dlv_ones == 4'd9) begin
          dlv_ones <= 4'd0;
          dlv_tens <= (dlv_tens == 4'd9) ? 4'd0 : dlv_tens + 4'd1;
        end else begin
          dlv_ones <= dlv_ones + 4'd1;
        end
      end

      if (state == S_UTURN && bus.uturn_finished) begin
        if (delivered) begin
          delivered <= 1'b0;
          empty_cnt <= '0;
        end else begin
          empty_cnt <= empty_cnt + EW'(1);
        end
      end
    end
  end

  assign bus.en_tracking  = en_tracking_q;
  assign bus.en_uturn     = en_uturn_q;
  assign bus.en_buzz      = en_buzz_q;
  assign bus.mission_done = mission_done_q;
  assign bus.fault        = fault_q;
  assign bus.ssd_code     = {ssd_state_code(state), 4'(obj_q), dlv_tens, dlv_ones};

endmodule
